// File: rtl/rdf_uart_pkg.sv
// Shared constants for the SDRAM read-FIFO UART dump path.
package rdf_uart_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LATCH   = 2'd1;
  localparam logic [1:0] SEND_LO = 2'd2;
  localparam logic [1:0] SEND_HI = 2'd3;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 217;

  // Index of the final bit period of a frame (stop bit plus idle gap periods).
  function automatic int frame_last(input int byte_gap);
    return FRAME_BITS - 1 + byte_gap;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with optional idle-high gap; accepts a new start on
// the done cycle so consecutive bytes abut with no hand-off bubble.
module uart_byte_tx
  import rdf_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int BYTE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [4:0]  BIT_LAST  = 5'(frame_last(BYTE_GAP));

  logic [15:0] baud_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        active;
  logic        bit_end;

  assign bit_end = active && (baud_cnt == BAUD_LAST);
  assign done    = bit_end && (bit_cnt == BIT_LAST);
  assign busy    = active;

  // Ones shift in behind the data, so the stop bit and gap fall out naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else if (start && (!active || done)) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data;
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (done) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/rdf_uart_tx.sv
// Pops 16-bit words from the SDRAM read FIFO and sends each as two UART
// bytes, low byte first, counting completed words.
//
//   state   | meaning
//   IDLE    | waiting for tx_en and a non-empty FIFO; pop strobe issued here
//   LATCH   | FIFO data valid; capture word and launch low byte
//   SEND_LO | low byte on the line; launch high byte on its done
//   SEND_HI | high byte on the line; count word on its done
module rdf_uart_tx
  import rdf_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int BYTE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic        rdf_empty,
  output logic        rdf_rd_en,
  input  logic [15:0] rdf_dout,
  output logic        rs232_tx,
  output logic        busy,
  output logic [15:0] word_cnt
);

  logic [1:0]  state;
  logic [15:0] word;
  logic        armed;
  logic        ser_start;
  logic [7:0]  ser_data;
  logic        ser_done;
  logic        ser_busy;

  // armed keeps the pop strobe quiet while reset is held and on the release cycle.
  assign rdf_rd_en = armed && (state == IDLE) && tx_en && !rdf_empty;
  assign busy      = (state != IDLE) || rdf_rd_en || ser_busy;

  always_comb begin
    ser_start = 1'b0;
    ser_data  = word[7:0];
    case (state)
      LATCH: begin
        ser_start = 1'b1;
        ser_data  = rdf_dout[7:0];
      end
      SEND_LO: begin
        if (ser_done) begin
          ser_start = 1'b1;
          ser_data  = word[15:8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      word_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (rdf_rd_en) state <= LATCH;
        end
        LATCH: begin
          word  <= rdf_dout;
          state <= SEND_LO;
        end
        SEND_LO: begin
          if (ser_done) state <= SEND_HI;
        end
        SEND_HI: begin
          if (ser_done) begin
            word_cnt <= word_cnt + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV),
    .BYTE_GAP (BYTE_GAP)
  ) u_byte_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ser_start),
    .data  (ser_data),
    .tx    (rs232_tx),
    .done  (ser_done),
    .busy  (ser_busy)
  );

endmodule

// File: tb/tb_rdf_uart_tx.sv
// Bench for rdf_uart_tx: two instances (gap 0 and gap 2) each checked every
// cycle against a timing model derived from the frame rules, plus a UART monitor.
module tb_rdf_uart_tx;

  localparam int B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int GAP = 2 * g;
    localparam int FR  = 10 + GAP;
    localparam int WP  = 2 + 2 * FR * B;

    logic        rst_n, tx_en, rdf_empty, rdf_rd_en, rs232_tx, busy;
    logic [15:0] rdf_dout, word_cnt;
    logic [15:0] fifo_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  ex_q[$];
    bit          fin = 0;
    bit          pend = 0;
    int          pops = 0;
    int          busy_cnt = 0;

    rdf_uart_tx #(.BAUD_DIV(B), .BYTE_GAP(GAP)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_en     (tx_en),
      .rdf_empty (rdf_empty),
      .rdf_rd_en (rdf_rd_en),
      .rdf_dout  (rdf_dout),
      .rs232_tx  (rs232_tx),
      .busy      (busy),
      .word_cnt  (word_cnt)
    );

    // FIFO model: data appears the cycle after the pop strobe.
    always @(negedge clk) begin
      if (rdf_rd_en) begin
        pend = 1;
        pops++;
      end
      if (busy) busy_cnt++;
    end
    always @(posedge clk) begin
      #1;
      if (pend) begin
        rdf_dout = fifo_q.pop_front();
        pend = 0;
      end
      rdf_empty = (fifo_q.size() == 0);
    end

    // Timing model: t counts cycles since the pop; a pop needs one clock edge out of reset.
    int          t = -1;
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] exp_w = 16'd0;
    bit          out_of_rst = 0;
    always @(posedge clk or negedge rst_n) out_of_rst <= rst_n ? 1'b1 : 1'b0;

    always @(negedge clk) begin
      logic       e_rd, e_tx;
      logic [7:0] by;
      int         k, bi;
      e_rd = 0;
      e_tx = 1;
      if (!rst_n) begin
        t = -1;
        exp_cnt = 16'd0;
      end else begin
        if (t == WP) begin
          t = -1;
          exp_cnt = exp_cnt + 16'd1;
        end
        if (t < 0 && out_of_rst && tx_en && !rdf_empty) begin
          e_rd = 1;
          t = 0;
          exp_w = fifo_q[0];
        end
        if (t >= 2) begin
          k  = t - 2;
          by = (k < FR * B) ? exp_w[7:0] : exp_w[15:8];
          bi = (k % (FR * B)) / B;
          if (bi == 0) e_tx = 0;
          else if (bi <= 8) e_tx = by[bi-1];
        end
      end
      chk($sformatf("g%0d rd_en t=%0d", g, t), rdf_rd_en, e_rd);
      chk($sformatf("g%0d tx t=%0d", g, t), rs232_tx, e_tx);
      chk($sformatf("g%0d busy t=%0d", g, t), busy, (t >= 0));
      chk($sformatf("g%0d word_cnt t=%0d", g, t), word_cnt, exp_cnt);
      if (t >= 0) t++;
    end

    // UART monitor: samples mid-bit, discards partial frames on reset.
    bit         rxing = 0;
    int         rc = 0;
    logic       prev_tx = 1'b1;
    logic [7:0] sh = 8'd0;
    always @(negedge clk) begin
      int bi;
      if (!rst_n) rxing = 0;
      else if (!rxing) begin
        if (prev_tx && !rs232_tx) begin
          rxing = 1;
          rc = 0;
        end
      end else begin
        rc++;
        if (rc > B / 2 && (rc - B / 2) % B == 0) begin
          bi = (rc - B / 2) / B;
          if (bi <= 8) sh = {rs232_tx, sh[7:1]};
          else begin
            if (rs232_tx) rx_q.push_back(sh);
            rxing = 0;
          end
        end
      end
      prev_tx = rs232_tx;
    end

    task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic push(input logic [15:0] w);
      fifo_q.push_back(w);
      rdf_empty = 0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
      int c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!(!busy && (rdf_empty || !tx_en)) && c < maxc);
      chk($sformatf("g%0d %s wait timeout", g, nm), (c >= maxc), 0);
      cyc(1);
    endtask

    task automatic wait_pop(input int maxc, input string nm);
      int c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!rdf_rd_en && c < maxc);
      chk($sformatf("g%0d %s pop timeout", g, nm), (c >= maxc), 0);
    endtask

    task automatic chk_rx(input string nm);
      chk($sformatf("g%0d %s byte count", g, nm), rx_q.size(), ex_q.size());
      for (int i = 0; i < ex_q.size() && i < rx_q.size(); i++)
        chk($sformatf("g%0d %s byte%0d", g, nm, i), rx_q[i], ex_q[i]);
    endtask

    initial begin
      rst_n = 0; tx_en = 1; rdf_empty = 1; rdf_dout = 16'd0;
      cyc(5);
      rst_n = 1;
      cyc(1000);
      chk($sformatf("g%0d idle word_cnt", g), word_cnt, 16'd0);
      chk($sformatf("g%0d idle pops", g), pops, 0);
      chk($sformatf("g%0d idle tx", g), rs232_tx, 1'b1);

      // single word
      rx_q.delete(); pops = 0; busy_cnt = 0;
      push(16'hA55A);
      wait_idle(400, "single");
      chk($sformatf("g%0d single pops", g), pops, 1);
      chk($sformatf("g%0d single busy cycles", g), busy_cnt, (GAP == 0) ? 82 : 98);
      chk($sformatf("g%0d single word_cnt", g), word_cnt, 16'd1);
      ex_q = '{8'h5A, 8'hA5};
      chk_rx("single");

      // burst of 8
      rx_q.delete(); pops = 0; ex_q.delete();
      for (int i = 0; i < 8; i++) begin
        push(16'(i));
        ex_q.push_back(8'(i));
        ex_q.push_back(8'h00);
      end
      wait_idle(2000, "burst");
      chk($sformatf("g%0d burst pops", g), pops, 8);
      chk($sformatf("g%0d burst word_cnt", g), word_cnt, 16'd9);
      chk_rx("burst");

      // enable dropped during low-byte data bits
      rx_q.delete(); pops = 0;
      push(16'h1234); push(16'h5678);
      wait_pop(50, "endrop");
      cyc(2 + 3 * B);
      tx_en = 0;
      wait_idle(1000, "endrop");
      chk($sformatf("g%0d endrop pops", g), pops, 1);
      chk($sformatf("g%0d endrop word_cnt", g), word_cnt, 16'd10);
      chk($sformatf("g%0d endrop empty", g), rdf_empty, 1'b0);
      chk($sformatf("g%0d endrop fifo left", g), fifo_q.size(), 1);
      tx_en = 1;
      wait_idle(400, "endrop2");
      chk($sformatf("g%0d endrop2 word_cnt", g), word_cnt, 16'd11);
      ex_q = '{8'h34, 8'h12, 8'h78, 8'h56};
      chk_rx("endrop");

      // reset during high-byte data bit 4
      rx_q.delete(); pops = 0;
      push(16'h0F3C); push(16'h8001);
      wait_pop(50, "rst");
      cyc(2 + FR * B + 5 * B + 1);
      chk($sformatf("g%0d hi bit4 low", g), rs232_tx, 1'b0);
      rst_n = 0;
      #1;
      chk($sformatf("g%0d async tx high", g), rs232_tx, 1'b1);
      chk($sformatf("g%0d async word_cnt", g), word_cnt, 16'd0);
      cyc(3);
      rst_n = 1;
      wait_idle(600, "rst");
      chk($sformatf("g%0d rst pops", g), pops, 2);
      chk($sformatf("g%0d rst word_cnt", g), word_cnt, 16'd1);
      ex_q = '{8'h3C, 8'h01, 8'h80};
      chk_rx("rst");

      // word_cnt wrap
      rx_q.delete();
      force u_dut.word_cnt = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      cyc(1);
      release u_dut.word_cnt;
      cyc(1);
      chk($sformatf("g%0d preload", g), word_cnt, 16'hFFFF);
      push(16'hBEEF);
      wait_idle(400, "wrap");
      chk($sformatf("g%0d wrap word_cnt", g), word_cnt, 16'h0000);
      ex_q = '{8'hEF, 8'hBE};
      chk_rx("wrap");

      cyc(5);
      fin = 1;
    end
  end

  initial begin
    int guard = 0;
    while (!(cfg[0].fin && cfg[1].fin) && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    chk("run completion timeout", (guard >= 50000), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
